ntt_butterfly_scheduler: RTL
============================

// Module: ntt_butterfly_scheduler
// PURPOSE
//  Upstream sequencer for the NTT butterfly datapath. Walks every stage of a
//  Gentleman-Sande NTT over an N-point coefficient RAM: generates pair read
//  addresses and twiddle-ROM addresses, then emits a load pulse aligned with
//  the returned a / a_pair / omega data feeding the butterfly pipelines.
//  Between stages it drains the butterfly pipeline so later stages never read
//  stale coefficients.
// PARAMETERS
//  N         1024  transform length, power of two
//  LOGN      10    log2(N), number of stages
//  DRAIN_CYC 8     en-qualified cycles waited after the last issue of a stage
//                  (butterfly pipeline depth + writeback)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  en         in   1      global pipeline enable, shared with butterfly stages
//  start      in   1      1-cycle pulse, begins a full transform
//  addr_a     out  LOGN   coefficient RAM read address, even member of pair
//  addr_b     out  LOGN   coefficient RAM read address, odd member of pair
//  omega_addr out  LOGN-1 twiddle ROM read address
//  bf_load    out  1      valid for a/a_pair/omega now on RAM/ROM outputs
//  stage_idx  out  4      current stage number (0..LOGN-1)
//  busy       out  1      high from start accept until done
//  done       out  1      1-cycle pulse after final stage has drained
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE; all counters 0; every output 0.
//  - All state advances only on cycles with en=1; en=0 freezes everything,
//    including bf_load, the drain counter and the outputs (held, not cleared).
//  - RAM and ROM are synchronous, 1-cycle read latency. bf_load is the issue
//    strobe registered once: addresses presented in cycle t -> bf_load=1 in t+1.
//  - FSM states: IDLE, ISSUE, DRAIN, DONE.
//    IDLE : start=1 & en -> ISSUE, busy<=1, stage=0, i=0. start in any other
//           state is ignored.
//    ISSUE: one butterfly per en cycle, i = 0..N/2-1. With s=stage, d=1<<s:
//             addr_a     = ((i>>s)<<(s+1)) | (i & (d-1))
//             addr_b     = addr_a | d
//             omega_addr = (i & (d-1)) << (LOGN-1-s)
//           i==N/2-1 -> DRAIN, drain counter cleared.
//    DRAIN: count DRAIN_CYC en cycles. At expiry: stage<LOGN-1 -> stage+1,
//           i=0, ISSUE; stage==LOGN-1 -> DONE.
//    DONE : done=1 for exactly one cycle, busy<=0, -> IDLE. In this cycle
//           start is not yet accepted; it is accepted from the next cycle
//           (back in IDLE).
//  - Per stage: N/2 issue cycles + DRAIN_CYC. Full transform:
//    LOGN*(N/2+DRAIN_CYC)+2 en cycles, start to done.
//  - Addresses are don't-care (held) outside ISSUE; only bf_load qualifies them.
//  - Counter widths are exact: i is LOGN-1 bits, with the wrap at N/2-1 detected
//    explicitly, never by overflow.
//  - Reset asserted mid-transform: immediate return to IDLE, busy=0,
//    bf_load=0, and no done pulse.
// STRUCTURE
//  - Shared package: NTT_N, NTT_LOGN, NTT_Q=12289, NTT_3Q=36867, FSM state
//    encodings, DRAIN_CYC default.
//  - One sub-module: ntt_addr_gen (combinational i,s -> addr_a/addr_b/
//    omega_addr).
//  - The FSM and counters stay in this file.
// TESTING
//  1 N=8,LOGN=3: start -> stage0 pairs (0,1)(2,3)(4,5)(6,7), omega_addr 0.
//  2 N=8 stage1: (0,2)w0 (1,3)w2 (4,6)w0 (5,7)w2.
//    N=8 stage2: (0,4)w0 (1,5)w1 (2,6)w2 (3,7)w3.
//  3 N=1024, DRAIN_CYC=8, en=1: done exactly 10*(512+8)+2 cycles after start.
//    bf_load count = 5120. Every bf_load trails its addresses by 1 cycle.
//  4 en toggled 0/1 every other cycle: identical address sequence, 2x
//    duration. Outputs held during en=0.
//  5 start pulsed while busy (mid stage 3): ignored, sequence unchanged.
//  6 reset low at stage 5, i=100: busy, bf_load, done are 0 the same cycle.
//    A new start then restarts from stage 0, i=0.

Source files
------------

// File: rtl/ntt_butterfly_scheduler_pkg.sv
// Shared constants and FSM encoding for the NTT butterfly scheduler.
package ntt_butterfly_scheduler_pkg;

    localparam int NTT_N         = 1024;
    localparam int NTT_LOGN      = 10;
    localparam int NTT_Q         = 12289;
    localparam int NTT_3Q        = 36867;
    // Butterfly pipeline depth plus writeback, in enabled cycles.
    localparam int NTT_DRAIN_CYC = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_butterfly_scheduler_addr_gen.sv
// Gentleman-Sande pair / twiddle address generator (purely combinational).
// For stage s (d = 1<<s) and butterfly index i:
//   addr_a = ((i>>s)<<(s+1)) | (i & (d-1)), addr_b = addr_a | d,
//   omega  = (i & (d-1)) << (LOGN-1-s)
module ntt_addr_gen #(
    parameter int LOGN = 10
) (
    input  logic [LOGN-2:0] i_i,
    input  logic [3:0]      i_stage,
    output logic [LOGN-1:0] o_addr_a,
    output logic [LOGN-1:0] o_addr_b,
    output logic [LOGN-2:0] o_omega_addr
);

    localparam logic [LOGN-1:0] ONE      = {{(LOGN-1){1'b0}}, 1'b1};
    localparam logic [3:0]      TOP_SHFT = 4'(LOGN - 1);

    logic [LOGN-1:0] w_i_ext;
    logic [LOGN-1:0] w_bit;
    logic [LOGN-1:0] w_mask;
    logic [LOGN-1:0] w_hi;

    assign w_i_ext      = {1'b0, i_i};
    assign w_bit        = ONE << i_stage;
    assign w_mask       = w_bit - ONE;
    // Upper index bits move up one place to open the gap for the pair bit.
    assign w_hi         = (w_i_ext >> i_stage) << (i_stage + 4'd1);
    assign o_addr_a     = w_hi | (w_i_ext & w_mask);
    assign o_addr_b     = o_addr_a | w_bit;
    assign o_omega_addr = (i_i & w_mask[LOGN-2:0]) << (TOP_SHFT - i_stage);

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// Stage sequencer for the NTT butterfly datapath: walks all LOGN stages,
// issues one butterfly per enabled cycle, drains the pipeline between stages.
// Handshake: bf_load is a valid-only strobe with no ready; the consumer shares
// en, so a held bf_load during en=0 is never consumed twice.
module ntt_butterfly_scheduler
    import ntt_butterfly_scheduler_pkg::*;
#(
    parameter int N         = NTT_N,
    parameter int LOGN      = NTT_LOGN,
    parameter int DRAIN_CYC = NTT_DRAIN_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            start,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-2:0] omega_addr,
    output logic            bf_load,
    output logic [3:0]      stage_idx,
    output logic            busy,
    output logic            done,
    output logic [1:0]      o_dbg_state
);

    localparam int               DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [LOGN-2:0]  I_LAST     = (LOGN - 1)'(N / 2 - 1);
    localparam logic [3:0]       LAST_STAGE = 4'(LOGN - 1);

    state_t          r_state;
    logic [LOGN-2:0] r_i;
    logic [3:0]      r_stage;
    logic [DW-1:0]   r_drain;
    logic            r_issue;
    logic            r_bf_load;
    logic            r_busy;
    logic            r_done;
    logic [LOGN-1:0] r_addr_a;
    logic [LOGN-1:0] r_addr_b;
    logic [LOGN-2:0] r_omega;

    logic [LOGN-1:0] w_addr_a;
    logic [LOGN-1:0] w_addr_b;
    logic [LOGN-2:0] w_omega;

    ntt_addr_gen #(.LOGN(LOGN)) u_addr_gen (
        .i_i          (r_i),
        .i_stage      (r_stage),
        .o_addr_a     (w_addr_a),
        .o_addr_b     (w_addr_b),
        .o_omega_addr (w_omega)
    );

    // Sequencer: addresses are registered, so r_issue marks the cycle they sit
    // on the pins; bf_load is that strobe delayed once for the RAM/ROM latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_i       <= '0;
            r_stage   <= '0;
            r_drain   <= '0;
            r_issue   <= 1'b0;
            r_bf_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_omega   <= '0;
        end else if (en) begin
            r_bf_load <= r_issue;
            r_issue   <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                        r_stage <= '0;
                        r_i     <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_addr_a <= w_addr_a;
                    r_addr_b <= w_addr_b;
                    r_omega  <= w_omega;
                    r_issue  <= 1'b1;
                    if (r_i == I_LAST) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        if (r_stage == LAST_STAGE) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stage <= r_stage + 4'd1;
                            r_i     <= '0;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign addr_a      = r_addr_a;
    assign addr_b      = r_addr_b;
    assign omega_addr  = r_omega;
    assign bf_load     = r_bf_load;
    assign stage_idx   = r_stage;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
